// File: rtl/parking_pkg.sv
// Shared definitions for the car-park gate logic: FSM state encoding,
// direction codes and default lot sizing.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN_IN  = 2'd1,
        ST_OPEN_OUT = 2'd2,
        ST_CLOSE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        DIR_IN   = 1'b0,
        DIR_EXIT = 1'b1
    } dir_t;

    localparam int DEFAULT_CAPACITY    = 3;
    localparam int DEFAULT_OPEN_CYCLES = 8;
    localparam int DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Open-window timer: cleared on load, counts while enabled, flags the last
// cycle of the window.
module gate_timer
    import parking_pkg::*;
#(
    parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expire
);

    localparam int TW = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(OPEN_CYCLES - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single barrier shared by entry and exit lanes: round-robin grant, bounded
// open window with timeout, and lot occupancy tracking.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = DEFAULT_CAPACITY,
    parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             vehicle_passed,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic             timeout,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] vacant,
    output logic             full,
    output logic [1:0]       arb_state
);

    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    arb_state_t       r_state;
    dir_t             r_last_served;
    logic [CNT_W-1:0] r_occupancy;
    logic             r_entry_grant;
    logic             r_exit_grant;
    logic             r_gate_open;
    logic             r_timeout;

    arb_state_t       w_next_state;
    dir_t             w_next_last;
    logic             w_entry_ok;
    logic             w_exit_ok;
    logic             w_full;
    logic             w_expire;
    logic             w_load;
    logic             w_enable;
    logic             w_entry_grant;
    logic             w_exit_grant;
    logic             w_gate_open;
    logic             w_timeout;
    logic             w_inc;
    logic             w_dec;

    assign w_full     = (r_occupancy == CAP_C);
    assign w_entry_ok = entry_req & ~w_full;
    assign w_exit_ok  = exit_req & (r_occupancy != '0);
    assign w_enable   = (r_state == ST_OPEN_IN) || (r_state == ST_OPEN_OUT);

    gate_timer #(
        .OPEN_CYCLES(OPEN_CYCLES)
    ) u_gate_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_load),
        .i_enable (w_enable),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_last   = r_last_served;
        w_entry_grant = 1'b0;
        w_exit_grant  = 1'b0;
        w_timeout     = 1'b0;
        w_inc         = 1'b0;
        w_dec         = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie, serve the direction that was not served last.
                if (w_entry_ok && (!w_exit_ok || r_last_served == DIR_EXIT)) begin
                    w_next_state  = ST_OPEN_IN;
                    w_next_last   = DIR_IN;
                    w_entry_grant = 1'b1;
                    w_load        = 1'b1;
                end else if (w_exit_ok) begin
                    w_next_state  = ST_OPEN_OUT;
                    w_next_last   = DIR_EXIT;
                    w_exit_grant  = 1'b1;
                    w_load        = 1'b1;
                end
            end
            ST_OPEN_IN, ST_OPEN_OUT: begin
                // A passage on the final window cycle still counts, no timeout.
                if (vehicle_passed) begin
                    w_next_state = ST_CLOSE;
                    w_inc        = (r_state == ST_OPEN_IN);
                    w_dec        = (r_state == ST_OPEN_OUT);
                end else if (w_expire) begin
                    w_next_state = ST_CLOSE;
                    w_timeout    = 1'b1;
                end
            end
            ST_CLOSE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        w_gate_open = (w_next_state == ST_OPEN_IN) || (w_next_state == ST_OPEN_OUT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_last_served <= DIR_EXIT;
            r_occupancy   <= '0;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_gate_open   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_last_served <= w_next_last;
            r_entry_grant <= w_entry_grant;
            r_exit_grant  <= w_exit_grant;
            r_gate_open   <= w_gate_open;
            r_timeout     <= w_timeout;
            if (w_inc) begin
                r_occupancy <= r_occupancy + 1'b1;
            end else if (w_dec) begin
                r_occupancy <= r_occupancy - 1'b1;
            end
        end
    end

    occupancy_in_range: assert property (@(posedge clock) disable iff (!reset_n)
        r_occupancy <= CAP_C);

    assign entry_grant = r_entry_grant;
    assign exit_grant  = r_exit_grant;
    assign gate_open   = r_gate_open;
    assign timeout     = r_timeout;
    assign occupancy   = r_occupancy;
    assign vacant      = CAP_C - r_occupancy;
    assign full        = w_full;
    assign arb_state   = r_state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: grant latency, capacity limit,
// round-robin alternation, open-window timeout and asynchronous reset.
module tb_parking_gate_arbiter;

    logic       clock;
    logic       reset_n;
    logic       entry_req;
    logic       exit_req;
    logic       vehicle_passed;
    logic       entry_grant;
    logic       exit_grant;
    logic       gate_open;
    logic       timeout;
    logic [7:0] occupancy;
    logic [7:0] vacant;
    logic       full;
    logic [1:0] arb_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_q[$];

    parking_gate_arbiter #(
        .CAPACITY(3),
        .OPEN_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .entry_req      (entry_req),
        .exit_req       (exit_req),
        .vehicle_passed (vehicle_passed),
        .entry_grant    (entry_grant),
        .exit_grant     (exit_grant),
        .gate_open      (gate_open),
        .timeout        (timeout),
        .occupancy      (occupancy),
        .vacant         (vacant),
        .full           (full),
        .arb_state      (arb_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Driver: one entry transaction with passage two cycles after the grant.
    task automatic drive_entry();
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        step();
        vehicle_passed = 1'b1;
        step();
        vehicle_passed = 1'b0;
        step();
    endtask

    task automatic drive_exit();
        exit_req = 1'b1;
        step();
        exit_req = 1'b0;
        step();
        vehicle_passed = 1'b1;
        step();
        vehicle_passed = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        entry_req      = 1'b0;
        exit_req       = 1'b0;
        vehicle_passed = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        n_checks++;
        if (arb_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", arb_state); end
        n_checks++;
        if (gate_open !== 1'b0 || entry_grant !== 1'b0 || exit_grant !== 1'b0 || timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got open=%0b eg=%0b xg=%0b to=%0b want all 0", gate_open, entry_grant, exit_grant, timeout);
        end
        n_checks++;
        if (occupancy !== 8'd0 || vacant !== 8'd3 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_counts: got occ=%0d vac=%0d full=%0b want 0/3/0", occupancy, vacant, full);
        end
    endtask

    task automatic test_entry_pass();
        int open_cycles;
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        n_checks++;
        if (entry_grant !== 1'b1 || arb_state !== 2'd1) begin
            n_errors++;
            $display("FAIL entry_grant_edge: got grant=%0b state=%0d want 1/1", entry_grant, arb_state);
        end
        open_cycles = gate_open ? 1 : 0;
        step();
        n_checks++;
        if (entry_grant !== 1'b0) begin n_errors++; $display("FAIL entry_grant_pulse: got %0b want 0", entry_grant); end
        if (gate_open) open_cycles++;
        step();
        if (gate_open) open_cycles++;
        vehicle_passed = 1'b1;
        step();
        vehicle_passed = 1'b0;
        if (gate_open) open_cycles++;
        n_checks++;
        if (open_cycles != 3) begin n_errors++; $display("FAIL entry_open_len: got %0d want 3", open_cycles); end
        n_checks++;
        if (arb_state !== 2'd3 || occupancy !== 8'd1 || vacant !== 8'd2) begin
            n_errors++;
            $display("FAIL entry_count: got state=%0d occ=%0d vac=%0d want 3/1/2", arb_state, occupancy, vacant);
        end
        step();
        n_checks++;
        if (arb_state !== 2'd0) begin n_errors++; $display("FAIL entry_back_idle: got %0d want 0", arb_state); end
    endtask

    task automatic test_full();
        int grants;
        int opens;
        drive_entry();
        drive_entry();
        n_checks++;
        if (occupancy !== 8'd3 || full !== 1'b1 || vacant !== 8'd0) begin
            n_errors++;
            $display("FAIL full_flags: got occ=%0d full=%0b vac=%0d want 3/1/0", occupancy, full, vacant);
        end
        grants = 0;
        opens  = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (entry_grant) grants++;
            if (gate_open) opens++;
        end
        entry_req = 1'b0;
        n_checks++;
        if (grants != 0 || opens != 0) begin
            n_errors++;
            $display("FAIL full_refuse: got grants=%0d open_cycles=%0d want 0/0", grants, opens);
        end
        vehicle_passed = 1'b1;
        step();
        vehicle_passed = 1'b0;
        step();
        n_checks++;
        if (occupancy !== 8'd3) begin n_errors++; $display("FAIL idle_pass_ignored: got %0d want 3", occupancy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] got;
        logic [1:0] want;
        drive_exit();
        drive_exit();
        n_checks++;
        if (occupancy !== 8'd1) begin n_errors++; $display("FAIL rr_setup_occ: got %0d want 1", occupancy); end
        // Last served was exit, so the tie goes to entry first.
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        for (int w = 0; w < 4; w++) begin
            step();
            if (entry_grant && !exit_grant) got = 2'd0;
            else if (exit_grant && !entry_grant) got = 2'd1;
            else got = 2'd2;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_errors++; $display("FAIL rr_grant_%0d: got %0d want %0d", w, got, want); end
            vehicle_passed = 1'b1;
            step();
            vehicle_passed = 1'b0;
            n_checks++;
            if (arb_state !== 2'd3 || gate_open !== 1'b0) begin
                n_errors++;
                $display("FAIL rr_close_%0d: got state=%0d open=%0b want 3/0", w, arb_state, gate_open);
            end
            step();
            n_checks++;
            if (arb_state !== 2'd0) begin n_errors++; $display("FAIL rr_idle_%0d: got %0d want 0", w, arb_state); end
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        n_checks++;
        if (occupancy !== 8'd1) begin n_errors++; $display("FAIL rr_final_occ: got %0d want 1", occupancy); end
    endtask

    task automatic test_timeout();
        int early;
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        early = 0;
        for (int i = 1; i < 8; i++) begin
            step();
            if (timeout || !gate_open) early++;
        end
        n_checks++;
        if (early != 0) begin n_errors++; $display("FAIL to_window: got %0d bad cycles want 0", early); end
        step();
        n_checks++;
        if (timeout !== 1'b1 || gate_open !== 1'b0 || arb_state !== 2'd3) begin
            n_errors++;
            $display("FAIL to_pulse: got to=%0b open=%0b state=%0d want 1/0/3", timeout, gate_open, arb_state);
        end
        n_checks++;
        if (occupancy !== 8'd1) begin n_errors++; $display("FAIL to_occ: got %0d want 1", occupancy); end
        step();
        n_checks++;
        if (timeout !== 1'b0 || arb_state !== 2'd0) begin
            n_errors++;
            $display("FAIL to_after: got to=%0b state=%0d want 0/0", timeout, arb_state);
        end
    endtask

    task automatic test_pass_on_expiry();
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        repeat (7) step();
        vehicle_passed = 1'b1;
        step();
        n_checks++;
        if (timeout !== 1'b0 || arb_state !== 2'd3 || occupancy !== 8'd2) begin
            n_errors++;
            $display("FAIL expiry_pass: got to=%0b state=%0d occ=%0d want 0/3/2", timeout, arb_state, occupancy);
        end
        // Held through the settle cycle: must not count again.
        step();
        vehicle_passed = 1'b0;
        n_checks++;
        if (occupancy !== 8'd2 || arb_state !== 2'd0) begin
            n_errors++;
            $display("FAIL close_pass_ignored: got occ=%0d state=%0d want 2/0", occupancy, arb_state);
        end
    endtask

    task automatic test_reset_mid_open();
        int grants;
        exit_req = 1'b1;
        step();
        exit_req = 1'b0;
        n_checks++;
        if (exit_grant !== 1'b1 || gate_open !== 1'b1 || arb_state !== 2'd2) begin
            n_errors++;
            $display("FAIL rst_setup: got xg=%0b open=%0b state=%0d want 1/1/2", exit_grant, gate_open, arb_state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (gate_open !== 1'b0 || occupancy !== 8'd0 || arb_state !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_async: got open=%0b occ=%0d state=%0d want 0/0/0", gate_open, occupancy, arb_state);
        end
        step();
        reset_n = 1'b1;
        exit_req = 1'b1;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (exit_grant || gate_open) grants++;
        end
        exit_req = 1'b0;
        n_checks++;
        if (grants != 0 || arb_state !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_exit_empty: got activity=%0d state=%0d want 0/0", grants, arb_state);
        end
    endtask

    initial begin
        test_reset();
        test_entry_pass();
        test_full();
        test_round_robin();
        test_timeout();
        test_pass_on_expiry();
        test_reset_mid_open();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
